// File: rtl/adder_reg_if.sv
// Operand/result bundle for adder_reg: two C_WIDTH-bit operands in,
// C_WIDTH+1-bit registered sum out.
interface adder_reg_if #(
   parameter int C_WIDTH = 4
);
   logic [C_WIDTH-1:0] a;
   logic [C_WIDTH-1:0] b;
   logic [C_WIDTH:0]   y;

   modport master (output a, output b, input y);
   modport slave  (input a, input b, output y);
endinterface

// File: rtl/adder_reg.sv
// Unsigned C_WIDTH-bit adder with carry-out and a one-cycle registered result.
// Carries are formed by two-level lookahead: within C_GROUP-bit groups and across groups.
module adder_reg #(
   parameter int C_WIDTH = 4,
   parameter int C_GROUP = 4
) (
   input  logic        clk,
   input  logic        reset,
   adder_reg_if.slave  bus
);
   localparam int NG = (C_WIDTH + C_GROUP - 1) / C_GROUP;

   if (C_WIDTH < 1 || C_WIDTH > 64 || C_GROUP < 1 || C_GROUP > C_WIDTH) begin : g_bad_param
      $error("adder_reg: illegal C_WIDTH/C_GROUP combination");
   end

   logic [C_WIDTH-1:0] p;
   logic [C_WIDTH-1:0] g;
   logic [C_WIDTH-1:0] c;
   logic [NG-1:0]      grp_g;
   logic [NG-1:0]      grp_p;
   logic [NG:0]        grp_c;
   logic [C_WIDTH:0]   sum;
   logic [C_WIDTH:0]   y_q;

   assign p = bus.a ^ bus.b;
   assign g = bus.a & bus.b;

   // The top group may be narrower than C_GROUP; its absent high bits contribute
   // nothing (p=0, g=0), so the group is simply built over the bits that exist and
   // its carry-out is exactly the carry out of bit C_WIDTH-1.
   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int LO = gi * C_GROUP;
      localparam int GW = (C_WIDTH - LO < C_GROUP) ? (C_WIDTH - LO) : C_GROUP;

      logic [GW-1:0] lg;
      logic [GW-1:0] lp;
      logic          gg;
      logic          gp;

      always_comb begin
         logic gacc;
         logic pacc;
         gacc = 1'b0;
         pacc = 1'b1;
         lg   = '0;
         lp   = '0;
         for (int j = 0; j < GW; j++) begin
            lg[j] = gacc;
            lp[j] = pacc;
            gacc  = g[LO + j] | (p[LO + j] & gacc);
            pacc  = p[LO + j] & pacc;
         end
         gg = gacc;
         gp = pacc;
      end

      assign grp_g[gi] = gg;
      assign grp_p[gi] = gp;

      for (genvar j = 0; j < GW; j++) begin : g_bit
         assign c[LO + j] = lg[j] | (lp[j] & grp_c[gi]);
      end
   end

   // Each group carry-in is taken straight from lower-group (G,P); no chained group carries.
   always_comb begin
      logic acc;
      grp_c    = '0;
      grp_c[0] = 1'b0;
      for (int i = 1; i <= NG; i++) begin
         acc = 1'b0;
         for (int k = 0; k < i; k++) begin
            acc = grp_g[k] | (grp_p[k] & acc);
         end
         grp_c[i] = acc;
      end
   end

   assign sum = {grp_c[NG], p ^ c};

   always_ff @(posedge clk) begin
      if (reset) y_q <= '0;
      else       y_q <= sum;
   end

   assign bus.y = y_q;
endmodule

// File: tb/tb_adder_reg.sv
// Scoreboard bench for adder_reg at widths 4, 10 (partial group) and 1.
module tb_adder_reg;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   adder_reg_if #(.C_WIDTH(4))  bus4 ();
   adder_reg_if #(.C_WIDTH(10)) bus10 ();
   adder_reg_if #(.C_WIDTH(1))  bus1 ();

   adder_reg #(.C_WIDTH(4),  .C_GROUP(4)) dut4  (.clk(clk), .reset(reset), .bus(bus4));
   adder_reg #(.C_WIDTH(10), .C_GROUP(4)) dut10 (.clk(clk), .reset(reset), .bus(bus10));
   adder_reg #(.C_WIDTH(1),  .C_GROUP(1)) dut1  (.clk(clk), .reset(reset), .bus(bus1));

   logic [4:0]  q4[$];
   logic [10:0] q10[$];
   logic [1:0]  q1[$];
   logic [4:0]  e4;
   logic [10:0] e10;
   logic [1:0]  e1;
   int total = 0;
   int bad = 0;
   int n4 = 0, n10 = 0, n1 = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Monitors: one result is owed per vector issued on the preceding falling edge
   always begin
      @(posedge clk); #1;
      if (q4.size() > 0) begin
         e4 = q4.pop_front();
         check($sformatf("w4 vec%0d", n4), 64'(bus4.y), 64'(e4));
         n4++;
      end
   end

   always begin
      @(posedge clk); #1;
      if (q10.size() > 0) begin
         e10 = q10.pop_front();
         check($sformatf("w10 vec%0d", n10), 64'(bus10.y), 64'(e10));
         n10++;
      end
   end

   always begin
      @(posedge clk); #1;
      if (q1.size() > 0) begin
         e1 = q1.pop_front();
         check($sformatf("w1 vec%0d", n1), 64'(bus1.y), 64'(e1));
         n1++;
      end
   end

   task automatic drv4(input logic r, input int av, input int bv, input int exp);
      @(negedge clk);
      reset  = r;
      bus4.a = 4'(av);
      bus4.b = 4'(bv);
      q4.push_back(5'(exp));
   endtask

   task automatic drv10(input logic r, input int av, input int bv, input int exp);
      @(negedge clk);
      reset   = r;
      bus10.a = 10'(av);
      bus10.b = 10'(bv);
      q10.push_back(11'(exp));
   endtask

   task automatic drv1(input logic r, input int av, input int bv, input int exp);
      @(negedge clk);
      reset  = r;
      bus1.a = 1'(av);
      bus1.b = 1'(bv);
      q1.push_back(2'(exp));
   endtask

   initial begin
      reset   = 1'b1;
      bus4.a  = '0; bus4.b  = '0;
      bus10.a = '0; bus10.b = '0;
      bus1.a  = '0; bus1.b  = '0;

      drv4(1'b1, 9, 7, 0);
      drv4(1'b1, 9, 7, 0);
      drv4(1'b0, 9, 7, 16);

      drv4(1'b0, 0, 0, 0);
      drv4(1'b0, 15, 15, 30);
      for (int bi = 0; bi < 16; bi++) begin
         for (int ai = 0; ai < 16; ai++) begin
            drv4(1'b0, ai, bi, ai + bi);
         end
      end

      drv4(1'b0, 15, 1, 16);
      drv4(1'b0, 8, 8, 16);
      drv4(1'b0, 7, 8, 15);

      drv4(1'b0, 12, 8, 20);
      drv4(1'b1, 12, 8, 0);
      drv4(1'b0, 3, 4, 7);

      drv10(1'b1, 5, 5, 0);
      drv10(1'b0, 1023, 1, 1024);
      drv10(1'b0, 1023, 1023, 2046);
      drv10(1'b0, 512, 511, 1023);
      drv10(1'b0, 341, 682, 1023);

      drv1(1'b0, 0, 0, 0);
      drv1(1'b0, 0, 1, 1);
      drv1(1'b0, 1, 0, 1);
      drv1(1'b0, 1, 1, 2);
      drv1(1'b1, 1, 1, 0);
      drv1(1'b0, 1, 1, 2);

      @(negedge clk);
      @(negedge clk);
      total++;
      if (q4.size() + q10.size() + q1.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q4.size() + q10.size() + q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adder_reg.md
Name: adder_reg

Overview:
- Parameterised unsigned binary adder with a registered output.
- Computes the full-precision sum of two C_WIDTH-bit operands, carry-out included, and presents it one clock after sampling.
- Used as a datapath arithmetic leaf. Also serves as the reference block for the exhaustive-sweep adder bench.

Parameters:
- C_WIDTH, 4, operand width in bits; legal range 1..64.
- C_GROUP, 4, carry-lookahead group size in bits; legal range 1..C_WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  C_WIDTH  operand A, unsigned.
- b  input  C_WIDTH  operand B, unsigned.
- y  output  C_WIDTH+1  registered sum a+b; y[C_WIDTH] is the carry-out.

Behaviour:
- Clocking: one clock (clk). Reset (reset) is synchronous and active-high, sampled only on the rising edge of clk. No asynchronous paths to y.
- Reset value: when reset=1 at a rising edge, y <= 0 (all C_WIDTH+1 bits).
  - A reset asserted in the middle of a stream overrides that cycle's sum.
  - The first non-reset edge after deassertion loads the sum of the a/b present at that edge.
- Latency: exactly 1 cycle, with no bubbles. Inputs are sampled every rising edge while reset=0, and y holds the result until the next edge. No handshake and no enable.
- Arithmetic:
  - y = zero_extend(a) + zero_extend(b), computed at C_WIDTH+1 bits.
  - The result is always exact. No overflow, no saturation, no wrap.
  - Maximum value is 2*(2^C_WIDTH - 1), for example 30 (5'b11110) at C_WIDTH=4.
- Structure (required, so that timing scales with width):
  - Split the operands into ceil(C_WIDTH/C_GROUP) groups.
  - Each group computes per-bit generate g=a&b and propagate p=a^b, then group generate/propagate (G,P) and its internal carries by lookahead.
  - Group carry-ins are formed by lookahead across groups, with carry-in to group 0 equal to 0.
  - Sum bit i = p[i] ^ c[i]. y[C_WIDTH] = carry out of the top bit.
  - A partial top group (C_WIDTH not a multiple of C_GROUP) treats missing high bits as p=0, g=0.
- Inputs: X/Z on a or b propagate to y only; they must not corrupt reset behaviour.
- The combinational path a/b -> y register must be fully contained in the block; there is no combinational input-to-output path.

Test Plan:
- C_WIDTH=4: hold reset=1 for 2 edges with a=9, b=7 -> y=0 throughout. Deassert reset -> y=16 one edge later.
- C_WIDTH=4 exhaustive sweep: step a 0..15 per cycle and increment b when a wraps from 15, covering all 256 pairs -> each y equals a+b one cycle later. The pair 15+15 gives y=30 (5'b11110). 0+0 gives 0.
- Carry chain: C_WIDTH=4, a=15, b=1 -> y=16 (bit4=1, low bits 0). a=8, b=8 -> y=16. a=7, b=8 -> y=15.
- Reset mid-stream: y=20 from a=12, b=8; assert reset for one edge -> y=0. Release with a=3, b=4 -> y=7 on the next edge.
- Wider / partial group: C_WIDTH=10, C_GROUP=4. a=1023, b=1 -> y=1024. a=1023, b=1023 -> y=2046. a=512, b=511 -> y=1023.
- Minimum width: C_WIDTH=1, C_GROUP=1. Pairs (0,0),(0,1),(1,0),(1,1) -> y=0,1,1,2 respectively, each one cycle after being applied.
